// File: rtl/osnt_ipg_monitor.sv
// =============================================================================
// Module      : osnt_ipg_monitor
// Description : Measures the inter-packet gap (SOP to SOP, in clock cycles) of
//               an AXI4-Stream, stamps it into tuser of the SOP beat through a
//               one-deep register slice, and keeps gap/packet statistics.
//               Statistics (gap_min, gap_max, pkt_cnt) are built only when the
//               macro IPG_MON_STATS_EN is defined; otherwise they read as 0.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module osnt_ipg_monitor #(
    parameter int C_S_AXIS_DATA_WIDTH   = 512,
    parameter int C_S_AXIS_TUSER_WIDTH  = 128,
    parameter int C_TUSER_TIMESTAMP_POS = 32,
    parameter int C_S_AXI_DATA_WIDTH    = 32
) (
    input  logic                                 axis_aclk,
    input  logic                                 axis_areset,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser,
    input  logic                                 s_axis_tvalid,
    input  logic                                 s_axis_tlast,
    output logic                                 s_axis_tready,

    output logic [C_S_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]     m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser,
    output logic                                 m_axis_tvalid,
    output logic                                 m_axis_tlast,
    input  logic                                 m_axis_tready,

    input  logic                                 sw_rst,
    input  logic                                 ipg_en,
    output logic [C_S_AXI_DATA_WIDTH-1:0]        gap_last,
    output logic [C_S_AXI_DATA_WIDTH-1:0]        gap_min,
    output logic [C_S_AXI_DATA_WIDTH-1:0]        gap_max,
    output logic [C_S_AXI_DATA_WIDTH-1:0]        pkt_cnt
);

    localparam logic [31:0] c_all_ones = 32'hFFFF_FFFF;

    logic [31:0]                         r_cyc;
    logic [31:0]                         r_sop_ts;
    logic [31:0]                         r_gap_last;
    logic                                r_first_seen;
    logic                                r_in_pkt;

    logic [C_S_AXIS_DATA_WIDTH-1:0]      r_m_tdata;
    logic [C_S_AXIS_DATA_WIDTH/8-1:0]    r_m_tkeep;
    logic [C_S_AXIS_TUSER_WIDTH-1:0]     r_m_tuser;
    logic                                r_m_tvalid;
    logic                                r_m_tlast;

    logic                                w_s_tready;
    logic                                w_accept;
    logic                                w_sop;
    logic                                w_eop;
    logic                                w_gap_valid;
    logic [31:0]                         w_gap;
    logic [C_S_AXIS_TUSER_WIDTH-1:0]     w_tuser;

    assign w_s_tready  = ~r_m_tvalid | m_axis_tready;
    assign w_accept    = s_axis_tvalid & w_s_tready;
    assign w_sop       = w_accept & ~r_in_pkt;
    assign w_eop       = w_accept & s_axis_tlast;

    // A SOP coinciding with sw_rst is treated as the first packet after clear.
    assign w_gap_valid = r_first_seen & ~sw_rst;
    assign w_gap       = w_gap_valid ? (r_cyc - r_sop_ts) : 32'd0;

    always_comb begin
        w_tuser = s_axis_tuser;
        if (w_sop && ipg_en) begin
            w_tuser[C_TUSER_TIMESTAMP_POS +: 32] = w_gap;
        end
    end

    // Free-running cycle counter; modulo-2^32 subtraction handles wrap.
    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            r_cyc <= 32'd0;
        end else begin
            r_cyc <= r_cyc + 32'd1;
        end
    end

    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            r_in_pkt     <= 1'b0;
            r_first_seen <= 1'b0;
            r_sop_ts     <= 32'd0;
            r_gap_last   <= 32'd0;
        end else begin
            if (w_accept) begin
                r_in_pkt <= ~s_axis_tlast;
            end

            if (w_sop) begin
                r_sop_ts     <= r_cyc;
                r_first_seen <= 1'b1;
            end else if (sw_rst) begin
                r_first_seen <= 1'b0;
            end

            if (sw_rst) begin
                r_gap_last <= 32'd0;
            end else if (w_sop && r_first_seen) begin
                r_gap_last <= w_gap;
            end
        end
    end

    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tkeep  <= '0;
            r_m_tuser  <= '0;
            r_m_tlast  <= 1'b0;
        end else if (w_s_tready) begin
            r_m_tvalid <= s_axis_tvalid;
            if (s_axis_tvalid) begin
                r_m_tdata <= s_axis_tdata;
                r_m_tkeep <= s_axis_tkeep;
                r_m_tuser <= w_tuser;
                r_m_tlast <= s_axis_tlast;
            end
        end
    end

    assign s_axis_tready = w_s_tready;
    assign m_axis_tvalid = r_m_tvalid;
    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tkeep  = r_m_tkeep;
    assign m_axis_tuser  = r_m_tuser;
    assign m_axis_tlast  = r_m_tlast;
    assign gap_last      = r_gap_last;

`ifdef IPG_MON_STATS_EN
    logic [31:0] r_gap_min;
    logic [31:0] r_gap_max;
    logic [31:0] r_pkt_cnt;

    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            r_gap_min <= c_all_ones;
            r_gap_max <= 32'd0;
            r_pkt_cnt <= 32'd0;
        end else if (sw_rst) begin
            r_gap_min <= c_all_ones;
            r_gap_max <= 32'd0;
            r_pkt_cnt <= 32'd0;
        end else begin
            if (w_sop && r_first_seen) begin
                if (w_gap < r_gap_min) begin
                    r_gap_min <= w_gap;
                end
                if (w_gap > r_gap_max) begin
                    r_gap_max <= w_gap;
                end
            end
            if (w_eop && (r_pkt_cnt != c_all_ones)) begin
                r_pkt_cnt <= r_pkt_cnt + 32'd1;
            end
        end
    end

    assign gap_min = r_gap_min;
    assign gap_max = r_gap_max;
    assign pkt_cnt = r_pkt_cnt;
`else
    assign gap_min = '0;
    assign gap_max = '0;
    assign pkt_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_osnt_ipg_monitor.sv
// =============================================================================
// Module      : tb_osnt_ipg_monitor
// Description : Directed self-checking bench for osnt_ipg_monitor; expected
//               statistics depend on whether IPG_MON_STATS_EN is defined.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_osnt_ipg_monitor;

    localparam int DW  = 512;
    localparam int UW  = 128;
    localparam int POS = 32;
    localparam int AW  = 32;
`ifdef IPG_MON_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            areset;
    logic [DW-1:0]   s_tdata;
    logic [DW/8-1:0] s_tkeep;
    logic [UW-1:0]   s_tuser;
    logic            s_tvalid;
    logic            s_tlast;
    logic            s_tready;
    logic [DW-1:0]   m_tdata;
    logic [DW/8-1:0] m_tkeep;
    logic [UW-1:0]   m_tuser;
    logic            m_tvalid;
    logic            m_tlast;
    logic            m_tready;
    logic            sw_rst;
    logic            ipg_en;
    logic [AW-1:0]   gap_last;
    logic [AW-1:0]   gap_min;
    logic [AW-1:0]   gap_max;
    logic [AW-1:0]   pkt_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    beat_t cap_q[$];

    always #5 clk = ~clk;

    osnt_ipg_monitor #(
        .C_S_AXIS_DATA_WIDTH   (DW),
        .C_S_AXIS_TUSER_WIDTH  (UW),
        .C_TUSER_TIMESTAMP_POS (POS),
        .C_S_AXI_DATA_WIDTH    (AW)
    ) dut (
        .axis_aclk     (clk),
        .axis_areset   (areset),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tuser  (s_tuser),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tuser  (m_tuser),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tlast  (m_tlast),
        .m_axis_tready (m_tready),
        .sw_rst        (sw_rst),
        .ipg_en        (ipg_en),
        .gap_last      (gap_last),
        .gap_min       (gap_min),
        .gap_max       (gap_max),
        .pkt_cnt       (pkt_cnt)
    );

    // Egress beats that will transfer on the next rising edge.
    always @(negedge clk) begin
        if (m_tvalid && m_tready) begin
            cap_q.push_back({m_tdata, m_tuser, m_tlast});
        end
    end

    function automatic logic [UW-1:0] mk_user(input logic [31:0] f);
        return {32'hA5A5_A5A5, 32'h5A5A_5A5A, f, 32'hC3C3_C3C3};
    endfunction

    function automatic logic [DW-1:0] mk_data(input logic [31:0] seed);
        return {16{seed}};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Presents one beat and returns on the negedge after it was accepted.
    task automatic send_beat(input logic [31:0] seed, input logic [31:0] f,
                             input logic last, input logic en);
        int t;
        s_tdata  = mk_data(seed);
        s_tkeep  = '1;
        s_tuser  = mk_user(f);
        s_tlast  = last;
        ipg_en   = en;
        s_tvalid = 1'b1;
        t = 0;
        while (!s_tready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            n_checks++;
            $display("FAIL accept_timeout: waited %0d cycles, required < 200", t);
        end
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic pulse_sw_rst();
        @(negedge clk);
        sw_rst = 1'b1;
        @(negedge clk);
        sw_rst = 1'b0;
    endtask

    task automatic test_reset();
        areset   = 1'b1;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tuser  = '0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b1;
        sw_rst   = 1'b0;
        ipg_en   = 1'b0;
        idle(3);
        #1;
        n_checks++; if (m_tvalid !== 1'b0) $display("FAIL rst_m_tvalid: got %b need 0", m_tvalid); else n_pass++;
        n_checks++; if (s_tready !== 1'b1) $display("FAIL rst_s_tready: got %b need 1", s_tready); else n_pass++;
        n_checks++; if (gap_last !== 32'd0) $display("FAIL rst_gap_last: got %h need 0", gap_last); else n_pass++;
        n_checks++; if (gap_min !== (STATS ? 32'hFFFF_FFFF : 32'd0)) $display("FAIL rst_gap_min: got %h need %h", gap_min, STATS ? 32'hFFFF_FFFF : 32'd0); else n_pass++;
        n_checks++; if (gap_max !== 32'd0) $display("FAIL rst_gap_max: got %h need 0", gap_max); else n_pass++;
        n_checks++; if (pkt_cnt !== 32'd0) $display("FAIL rst_pkt_cnt: got %h need 0", pkt_cnt); else n_pass++;
        @(negedge clk);
        areset = 1'b0;
    endtask

    task automatic test_gap_basic();
        pulse_sw_rst();
        #1 cap_q.delete();
        send_beat(32'h0000_0001, 32'h1111_1111, 1'b1, 1'b1);
        idle(99);
        send_beat(32'h0000_0002, 32'h2222_2222, 1'b1, 1'b1);
        idle(2);
        #1;
        n_checks++; if (cap_q.size() != 2) $display("FAIL basic_beats: got %0d need 2", cap_q.size()); else n_pass++;
        n_checks++; if (cap_q[0].user !== mk_user(32'd0)) $display("FAIL basic_user0: got %h need %h", cap_q[0].user, mk_user(32'd0)); else n_pass++;
        n_checks++; if (cap_q[1].user !== mk_user(32'd100)) $display("FAIL basic_user1: got %h need %h", cap_q[1].user, mk_user(32'd100)); else n_pass++;
        n_checks++; if (cap_q[1].data !== mk_data(32'h0000_0002)) $display("FAIL basic_data1: got %h need %h", cap_q[1].data[31:0], 32'h2); else n_pass++;
        n_checks++; if (gap_last !== 32'd100) $display("FAIL basic_gap_last: got %0d need 100", gap_last); else n_pass++;
        n_checks++; if (gap_min !== (STATS ? 32'd100 : 32'd0)) $display("FAIL basic_gap_min: got %0d need %0d", gap_min, STATS ? 100 : 0); else n_pass++;
        n_checks++; if (gap_max !== (STATS ? 32'd100 : 32'd0)) $display("FAIL basic_gap_max: got %0d need %0d", gap_max, STATS ? 100 : 0); else n_pass++;
        n_checks++; if (pkt_cnt !== (STATS ? 32'd2 : 32'd0)) $display("FAIL basic_pkt_cnt: got %0d need %0d", pkt_cnt, STATS ? 2 : 0); else n_pass++;
    endtask

    task automatic test_backpressure();
        pulse_sw_rst();
        #1 cap_q.delete();
        fork
            begin
                send_beat(32'h0000_00A0, 32'hAAAA_AAAA, 1'b0, 1'b1);
                send_beat(32'h0000_00B0, 32'hAAAA_AAAA, 1'b0, 1'b1);
                send_beat(32'h0000_00C0, 32'hAAAA_AAAA, 1'b1, 1'b1);
            end
            begin
                @(posedge clk);
                #2 m_tready = 1'b0;
                repeat (5) @(posedge clk);
                #2;
                n_checks++; if (m_tvalid !== 1'b1) $display("FAIL bp_hold_valid: got %b need 1", m_tvalid); else n_pass++;
                n_checks++; if (m_tdata !== mk_data(32'h0000_00A0)) $display("FAIL bp_hold_data: got %h need %h", m_tdata[31:0], 32'hA0); else n_pass++;
                n_checks++; if (s_tready !== 1'b0) $display("FAIL bp_s_tready: got %b need 0", s_tready); else n_pass++;
                m_tready = 1'b1;
            end
        join
        idle(3);
        #1;
        n_checks++; if (cap_q.size() != 3) $display("FAIL bp_beats: got %0d need 3", cap_q.size()); else n_pass++;
        n_checks++; if (cap_q[0].data !== mk_data(32'h0000_00A0) || cap_q[0].last !== 1'b0) $display("FAIL bp_beat0: got %h/%b need a0/0", cap_q[0].data[31:0], cap_q[0].last); else n_pass++;
        n_checks++; if (cap_q[1].data !== mk_data(32'h0000_00B0) || cap_q[1].last !== 1'b0) $display("FAIL bp_beat1: got %h/%b need b0/0", cap_q[1].data[31:0], cap_q[1].last); else n_pass++;
        n_checks++; if (cap_q[2].data !== mk_data(32'h0000_00C0) || cap_q[2].last !== 1'b1) $display("FAIL bp_beat2: got %h/%b need c0/1", cap_q[2].data[31:0], cap_q[2].last); else n_pass++;
        n_checks++; if (cap_q[0].user !== mk_user(32'd0)) $display("FAIL bp_user0: got %h need %h", cap_q[0].user, mk_user(32'd0)); else n_pass++;
        n_checks++; if (cap_q[1].user !== mk_user(32'hAAAA_AAAA)) $display("FAIL bp_user1: got %h need %h", cap_q[1].user, mk_user(32'hAAAA_AAAA)); else n_pass++;
        n_checks++; if (cap_q[2].user !== mk_user(32'hAAAA_AAAA)) $display("FAIL bp_user2: got %h need %h", cap_q[2].user, mk_user(32'hAAAA_AAAA)); else n_pass++;
        n_checks++; if (pkt_cnt !== (STATS ? 32'd1 : 32'd0)) $display("FAIL bp_pkt_cnt: got %0d need %0d", pkt_cnt, STATS ? 1 : 0); else n_pass++;
    endtask

    task automatic test_wrap();
        pulse_sw_rst();
        idle(1);
        force dut.r_cyc = 32'hFFFF_FFF8;
        #1 release dut.r_cyc;
        cap_q.delete();
        send_beat(32'h0000_0010, 32'h5555_5555, 1'b1, 1'b1);
        idle(15);
        send_beat(32'h0000_0011, 32'h5555_5555, 1'b1, 1'b1);
        idle(2);
        #1;
        n_checks++; if (cap_q.size() != 2) $display("FAIL wrap_beats: got %0d need 2", cap_q.size()); else n_pass++;
        n_checks++; if (cap_q[1].user !== mk_user(32'h10)) $display("FAIL wrap_user1: got %h need %h", cap_q[1].user, mk_user(32'h10)); else n_pass++;
        n_checks++; if (gap_last !== 32'h10) $display("FAIL wrap_gap_last: got %h need 10", gap_last); else n_pass++;
        n_checks++; if (gap_max !== (STATS ? 32'h10 : 32'd0)) $display("FAIL wrap_gap_max: got %h need %h", gap_max, STATS ? 32'h10 : 32'd0); else n_pass++;
    endtask

    task automatic test_min_max();
        pulse_sw_rst();
        send_beat(32'h0000_0020, 32'h0, 1'b1, 1'b1);
        idle(49);
        send_beat(32'h0000_0021, 32'h0, 1'b1, 1'b1);
        idle(19);
        send_beat(32'h0000_0022, 32'h0, 1'b1, 1'b1);
        idle(79);
        send_beat(32'h0000_0023, 32'h0, 1'b1, 1'b1);
        idle(2);
        #1;
        n_checks++; if (gap_last !== 32'd80) $display("FAIL mm_gap_last: got %0d need 80", gap_last); else n_pass++;
        n_checks++; if (gap_min !== (STATS ? 32'd20 : 32'd0)) $display("FAIL mm_gap_min: got %0d need %0d", gap_min, STATS ? 20 : 0); else n_pass++;
        n_checks++; if (gap_max !== (STATS ? 32'd80 : 32'd0)) $display("FAIL mm_gap_max: got %0d need %0d", gap_max, STATS ? 80 : 0); else n_pass++;
        n_checks++; if (pkt_cnt !== (STATS ? 32'd4 : 32'd0)) $display("FAIL mm_pkt_cnt: got %0d need %0d", pkt_cnt, STATS ? 4 : 0); else n_pass++;
        pulse_sw_rst();
        #1;
        n_checks++; if (gap_min !== (STATS ? 32'hFFFF_FFFF : 32'd0)) $display("FAIL swr_gap_min: got %h need %h", gap_min, STATS ? 32'hFFFF_FFFF : 32'd0); else n_pass++;
        n_checks++; if (gap_max !== 32'd0) $display("FAIL swr_gap_max: got %h need 0", gap_max); else n_pass++;
        n_checks++; if (pkt_cnt !== 32'd0) $display("FAIL swr_pkt_cnt: got %h need 0", pkt_cnt); else n_pass++;
        n_checks++; if (gap_last !== 32'd0) $display("FAIL swr_gap_last: got %h need 0", gap_last); else n_pass++;
        cap_q.delete();
        idle(10);
        send_beat(32'h0000_0024, 32'h7777_7777, 1'b1, 1'b1);
        idle(2);
        #1;
        n_checks++; if (cap_q[0].user !== mk_user(32'd0)) $display("FAIL swr_first_user: got %h need %h", cap_q[0].user, mk_user(32'd0)); else n_pass++;
    endtask

    task automatic test_sop_with_sw_rst();
        idle(10);
        #1 cap_q.delete();
        @(negedge clk);
        sw_rst = 1'b1;
        send_beat(32'h0000_0030, 32'h3333_3333, 1'b1, 1'b1);
        sw_rst = 1'b0;
        idle(1);
        #1;
        n_checks++; if (cap_q[0].user !== mk_user(32'd0)) $display("FAIL coinc_user: got %h need %h", cap_q[0].user, mk_user(32'd0)); else n_pass++;
        n_checks++; if (gap_last !== 32'd0) $display("FAIL coinc_gap_last: got %0d need 0", gap_last); else n_pass++;
        n_checks++; if (pkt_cnt !== 32'd0) $display("FAIL coinc_pkt_cnt: got %0d need 0", pkt_cnt); else n_pass++;
        n_checks++; if (gap_min !== (STATS ? 32'hFFFF_FFFF : 32'd0)) $display("FAIL coinc_gap_min: got %h need %h", gap_min, STATS ? 32'hFFFF_FFFF : 32'd0); else n_pass++;
        idle(28);
        send_beat(32'h0000_0031, 32'h3333_3333, 1'b1, 1'b1);
        idle(2);
        #1;
        n_checks++; if (cap_q[1].user !== mk_user(32'd30)) $display("FAIL coinc_next_user: got %h need %h", cap_q[1].user, mk_user(32'd30)); else n_pass++;
        n_checks++; if (gap_last !== 32'd30) $display("FAIL coinc_next_gap: got %0d need 30", gap_last); else n_pass++;
        n_checks++; if (pkt_cnt !== (STATS ? 32'd1 : 32'd0)) $display("FAIL coinc_next_cnt: got %0d need %0d", pkt_cnt, STATS ? 1 : 0); else n_pass++;
        n_checks++; if (gap_min !== (STATS ? 32'd30 : 32'd0)) $display("FAIL coinc_next_min: got %0d need %0d", gap_min, STATS ? 30 : 0); else n_pass++;
    endtask

    task automatic test_ipg_disable();
        idle(5);
        #1 cap_q.delete();
        @(negedge clk);
        send_beat(32'h0000_0040, 32'hDEAD_BEEF, 1'b1, 1'b0);
        idle(2);
        #1;
        n_checks++; if (cap_q.size() != 1) $display("FAIL dis_beats: got %0d need 1", cap_q.size()); else n_pass++;
        n_checks++; if (cap_q[0].user !== mk_user(32'hDEAD_BEEF)) $display("FAIL dis_user: got %h need %h", cap_q[0].user, mk_user(32'hDEAD_BEEF)); else n_pass++;
    endtask

    task automatic test_async_reset();
        idle(3);
        send_beat(32'h0000_0050, 32'h4444_4444, 1'b0, 1'b1);
        #1 areset = 1'b1;
        #1;
        n_checks++; if (m_tvalid !== 1'b0) $display("FAIL ar_m_tvalid: got %b need 0", m_tvalid); else n_pass++;
        n_checks++; if (s_tready !== 1'b1) $display("FAIL ar_s_tready: got %b need 1", s_tready); else n_pass++;
        n_checks++; if (gap_last !== 32'd0) $display("FAIL ar_gap_last: got %h need 0", gap_last); else n_pass++;
        @(negedge clk);
        areset = 1'b0;
        #1 cap_q.delete();
        idle(5);
        send_beat(32'h0000_0051, 32'h1234_5678, 1'b1, 1'b1);
        idle(2);
        #1;
        n_checks++; if (cap_q.size() != 1) $display("FAIL ar_beats: got %0d need 1", cap_q.size()); else n_pass++;
        n_checks++; if (cap_q[0].user !== mk_user(32'd0)) $display("FAIL ar_sop_user: got %h need %h", cap_q[0].user, mk_user(32'd0)); else n_pass++;
        n_checks++; if (pkt_cnt !== (STATS ? 32'd1 : 32'd0)) $display("FAIL ar_pkt_cnt: got %0d need %0d", pkt_cnt, STATS ? 1 : 0); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_gap_basic();
        test_backpressure();
        test_wrap();
        test_min_max();
        test_sop_with_sw_rst();
        test_ipg_disable();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
